// File: rtl/uart_test_panel.sv
// uart_test_panel
//   Front-panel controller for a UART test rig. Raw push-buttons are
//   synchronised and debounced. Channel 0 sends the switch value through
//   the UART transmitter handshake. The other channels give either a
//   one-cycle press pulse or a toggled configuration bit. Received bytes
//   are latched for display and counted.
//
//   Optional feature (macro AUTO_REPEAT_EN): holding the send button
//   re-issues a send every REPEAT_CYCLES cycles while the sender is idle.
//   Without the macro there is exactly one send per press, and no repeat
//   logic is built.
//
// Ports
//   clk        in   system clock, all logic on rising edge
//   rst        in   asynchronous active-low reset
//   btn        in   [BTN_N]  raw button levels, 1 = pressed
//   sw         in   [DATA_W] switch value to transmit
//   tx_ready   in   transmitter idle, may accept a byte
//   rx_valid   in   one-cycle strobe, rx_data holds a new byte
//   rx_data    in   [DATA_W] received byte
//   tx_data    out  [DATA_W] byte presented to transmitter
//   tx_send    out  one-cycle transmit request
//   btn_pulse  out  [BTN_N]  one-cycle press pulse per channel
//   cfg        out  [BTN_N]  toggle states (toggle channels only, else 0)
//   disp_rx    out  [DATA_W] last received byte
//   rx_count   out  [8]      received byte count (wraps)
module uart_test_panel #(
  parameter int                BTN_N         = 4,
  parameter int                DEB_CYCLES    = 50000,
  parameter logic [BTN_N-1:0]  TOGGLE_MASK   = 4'b0110,
  parameter int                DATA_W        = 8,
  parameter int                REPEAT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BTN_N-1:0]  btn,
  input  logic [DATA_W-1:0] sw,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_send,
  output logic [BTN_N-1:0]  btn_pulse,
  output logic [BTN_N-1:0]  cfg,
  output logic [DATA_W-1:0] disp_rx,
  output logic [7:0]        rx_count
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  // Channel 0 is the send button and never toggles.
  localparam logic [BTN_N-1:0] TOGGLE_EFF = TOGGLE_MASK & ~BTN_N'(1);

  logic [BTN_N-1:0] deb;
  logic [BTN_N-1:0] deb_d;
  logic             send_req;

  // Per-channel synchroniser and debouncer.
  for (genvar gi = 0; gi < BTN_N; gi++) begin : g_chan
    logic             sync_meta;
    logic             sync_level;
    logic             deb_level;
    logic [DEB_W-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_meta  <= 1'b0;
        sync_level <= 1'b0;
        deb_level  <= 1'b0;
        deb_cnt    <= '0;
      end else begin
        sync_meta  <= btn[gi];
        sync_level <= sync_meta;
        // Accept a level change only after it has been seen for
        // DEB_CYCLES consecutive cycles; any bounce restarts the count.
        if (sync_level != deb_level) begin
          if (deb_cnt == DEB_MAX) begin
            deb_level <= sync_level;
            deb_cnt   <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end else begin
          deb_cnt <= '0;
        end
      end
    end

    assign deb[gi] = deb_level;
  end

  // Rising-edge detect of the debounced level, plus toggle registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_d     <= '0;
      btn_pulse <= '0;
      cfg       <= '0;
    end else begin
      deb_d     <= deb;
      btn_pulse <= deb & ~deb_d;
      cfg       <= cfg ^ (btn_pulse & TOGGLE_EFF);
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             auto_req;

  // The counter restarts on the press pulse, so the first repeat lands
  // REPEAT_CYCLES after it. Requests that arrive while the sender is busy
  // are dropped by the FSM, the same as an extra button press would be.
  assign auto_req = deb[0] && (rep_cnt == REP_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt <= '0;
    end else if (!deb[0] || btn_pulse[0] || (rep_cnt == REP_MAX)) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign send_req = btn_pulse[0] | auto_req;
`else
  assign send_req = btn_pulse[0];
`endif

  // Send FSM: latch the switches, wait for the transmitter, strobe once.
  typedef enum logic [1:0] {IDLE, WAIT_RDY, SEND} state_t;
  state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx_data <= '0;
      tx_send <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      case (state)
        IDLE: begin
          if (send_req) begin
            tx_data <= sw;
            state   <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (tx_ready) begin
            tx_send <= 1'b1;
            state   <= SEND;
          end
        end
        SEND:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Receive capture, independent of the send path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_rx  <= '0;
      rx_count <= '0;
    end else if (rx_valid) begin
      disp_rx  <= rx_data;
      rx_count <= rx_count + 8'd1;
    end
  end

endmodule
